// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL bit layout, mode encodings, FSM states and bridge base addresses.
package timer_counter_pkg;

    localparam logic [1:0] REG_CTRL   = 2'b00;
    localparam logic [1:0] REG_PRESET = 2'b01;
    localparam logic [1:0] REG_COUNT  = 2'b10;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } timer_state_e;

    localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with CTRL/PRESET/COUNT word registers and a maskable irq.
// The register file and the sequencing FSM share one next-state block.
//
// state   | meaning
// IDLE    | waiting for CTRL.Enable; clears the irq flag when leaving
// LOAD    | COUNT <= PRESET
// CNT     | counting down while Enable stays set
// INT     | terminal count reached; one-shot drops Enable, reload re-arms
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] preset_q, preset_d;
    logic [DATA_W-1:0] count_q, count_d;
    timer_state_e      state_q, state_d;
    logic              irq_flag_q, irq_flag_d;

    logic [1:0] reg_sel;
    logic       unused_addr;

    assign reg_sel     = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes come last so a CPU write to CTRL overrides the one-shot clear.
        if (we) begin
            case (reg_sel)
                REG_CTRL:   ctrl_d   = wdata[CTRL_W-1:0];
                REG_PRESET: preset_d = wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
            REG_PRESET: rdata = preset_q;
            REG_COUNT:  rdata = count_q;
            default:    rdata = '0;
        endcase
    end

    assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot, auto-reload,
// masking, pause/reload, write collision and asynchronous reset.
module tb_timer_counter;
    import timer_counter_pkg::*;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic [31:0]       addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              irq;

    int n_chk = 0;
    int n_err = 0;

    timer_counter #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [1:0] off);
        return TIMER0_BASE + {28'h0, off, 2'b00};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
        addr  = reg_addr(off);
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        addr = reg_addr(off);
        #1;
        check(tag, rdata, exp);
    endtask

    // Asserts reset mid-cycle and verifies the asynchronous clear before any edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_irq", {31'h0, irq}, 32'h0);
        chk_reg("rst_ctrl", REG_CTRL, 32'h0);
        chk_reg("rst_count", REG_COUNT, 32'h0);
        #1;
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        addr  = reg_addr(REG_CTRL);
        wdata = '0;
        #23;
        reset = 1'b1;
        step(1);

        chk_reg("init_ctrl", REG_CTRL, 32'h0);
        chk_reg("init_preset", REG_PRESET, 32'h0);
        chk_reg("init_count", REG_COUNT, 32'h0);
        chk_reg("init_reg3", 2'b11, 32'h0);
        check("init_irq", {31'h0, irq}, 32'h0);

        // one-shot, PRESET=3
        bus_write(REG_PRESET, 32'd3);
        bus_write(REG_CTRL, 32'h9);
        chk_reg("os_ctrl_wr", REG_CTRL, 32'h9);
        step(1);
        chk_reg("os_load_cnt", REG_COUNT, 32'd0);
        step(1);
        chk_reg("os_cnt3", REG_COUNT, 32'd3);
        step(1);
        chk_reg("os_cnt2", REG_COUNT, 32'd2);
        step(1);
        chk_reg("os_cnt1", REG_COUNT, 32'd1);
        check("os_irq_pre", {31'h0, irq}, 32'h0);
        step(1);
        chk_reg("os_cnt0", REG_COUNT, 32'd0);
        check("os_irq_int", {31'h0, irq}, 32'h1);
        step(1);
        chk_reg("os_ctrl_after", REG_CTRL, 32'h8);
        check("os_irq_hold", {31'h0, irq}, 32'h1);
        step(3);
        check("os_irq_hold3", {31'h0, irq}, 32'h1);
        chk_reg("os_cnt_stay", REG_COUNT, 32'd0);

        // writes to COUNT and to the unused slot are ignored
        bus_write(REG_COUNT, 32'h1234);
        chk_reg("ign_count", REG_COUNT, 32'd0);
        bus_write(2'b11, 32'hffff_ffff);
        chk_reg("ign_reg3", 2'b11, 32'h0);
        chk_reg("ign_ctrl", REG_CTRL, 32'h8);
        do_reset();

        // auto-reload, PRESET=2: irq pulse on k = 4, 9, 14 after the CTRL write
        bus_write(REG_PRESET, 32'd2);
        chk_reg("ar_preset", REG_PRESET, 32'd2);
        bus_write(REG_CTRL, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check($sformatf("ar_irq_%0d", k), {31'h0, irq}, {31'h0, (k % 5) == 4});
            if ((k % 5) == 2) chk_reg($sformatf("ar_cnt_%0d", k), REG_COUNT, 32'd2);
        end
        do_reset();

        // masked: PRESET=0, IM=0, then unmask
        bus_write(REG_CTRL, 32'h1);
        step(2);
        chk_reg("mk_cnt0", REG_COUNT, 32'd0);
        step(1);
        check("mk_irq_masked", {31'h0, irq}, 32'h0);
        step(1);
        chk_reg("mk_ctrl_off", REG_CTRL, 32'h0);
        bus_write(REG_CTRL, 32'h8);
        check("mk_irq_unmask", {31'h0, irq}, 32'h1);
        do_reset();

        // pause at COUNT=4, then reload from the new PRESET
        bus_write(REG_PRESET, 32'd6);
        bus_write(REG_CTRL, 32'h9);
        step(3);
        chk_reg("pz_cnt5", REG_COUNT, 32'd5);
        bus_write(REG_CTRL, 32'h8);
        chk_reg("pz_cnt4", REG_COUNT, 32'd4);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk_reg($sformatf("pz_hold_%0d", k), REG_COUNT, 32'd4);
        end
        bus_write(REG_PRESET, 32'd10);
        bus_write(REG_CTRL, 32'h9);
        step(1);
        chk_reg("pz_load_old", REG_COUNT, 32'd4);
        step(1);
        chk_reg("pz_reload10", REG_COUNT, 32'd10);
        do_reset();

        // CPU write to CTRL in the INT cycle wins over the one-shot clear
        bus_write(REG_PRESET, 32'd2);
        bus_write(REG_CTRL, 32'h9);
        step(4);
        check("col_irq_int", {31'h0, irq}, 32'h1);
        bus_write(REG_CTRL, 32'h9);
        chk_reg("col_ctrl", REG_CTRL, 32'h9);
        check("col_irq_idle", {31'h0, irq}, 32'h1);
        step(1);
        check("col_irq_clr", {31'h0, irq}, 32'h0);
        step(1);
        chk_reg("col_recount", REG_COUNT, 32'd2);
        do_reset();

        // reset in the middle of a count
        bus_write(REG_PRESET, 32'd5);
        bus_write(REG_CTRL, 32'h9);
        step(2);
        chk_reg("mid_cnt5", REG_COUNT, 32'd5);
        do_reset();
        step(2);
        chk_reg("mid_idle", REG_COUNT, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
